ram_arbiter: RTL and testbench

Two-requester arbiter that shares the single data RAM between the CPU load/store path (port 0) and the firmware loader/debug path (port 1). It accepts at most one access per cycle, registers it onto the RAM port, and returns read data to the winning requester with fixed latency. It sits between the ALU's memory interface, the loader, and `ram`, and is the only driver of the RAM address/write-enable.

---
 rtl/ram_arbiter.sv | 120 ++++++++++++
 tb/tb_ram_arbiter.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Two-port arbiter in front of the shared data RAM: one registered access per cycle,
// bounded bursts per owner, and read data returned to the winner two cycles after grant.
module ram_arbiter #(
  parameter int RAM_WIDTH  = 31,
  parameter int DATA_WIDTH = 32,
  parameter int MAX_BURST  = 4
) (
  input  logic                  clk,
  input  logic                  a_reset_n,
  input  logic                  m0_req,
  input  logic                  m1_req,
  input  logic                  m0_we,
  input  logic                  m1_we,
  input  logic [RAM_WIDTH-1:0]  m0_addr,
  input  logic [RAM_WIDTH-1:0]  m1_addr,
  input  logic [DATA_WIDTH-1:0] m0_wdata,
  input  logic [DATA_WIDTH-1:0] m1_wdata,
  output logic                  m0_gnt,
  output logic                  m1_gnt,
  output logic                  m0_rvalid,
  output logic                  m1_rvalid,
  output logic [DATA_WIDTH-1:0] m0_rdata,
  output logic [DATA_WIDTH-1:0] m1_rdata,
  output logic [RAM_WIDTH-1:0]  ram_address,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  input  logic [DATA_WIDTH-1:0] ram_rdata
);

  localparam int CW = $clog2(MAX_BURST + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(MAX_BURST);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  typedef enum logic [1:0] {IDLE, OWN0, OWN1} state_t;

  state_t        state, state_nxt;
  logic          last, last_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    tag1, tag2;  // {valid, port}

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      state <= IDLE;
      last  <= 1'b1;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      last  <= last_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_comb begin
    m0_gnt    = 1'b0;
    m1_gnt    = 1'b0;
    state_nxt = IDLE;
    cnt_nxt   = '0;
    last_nxt  = last;
    case (state)
      OWN0: begin
        if (m0_req && (cnt < CNT_MAX || !m1_req)) m0_gnt = 1'b1;
        else if (m1_req)                          m1_gnt = 1'b1;
      end
      OWN1: begin
        if (m1_req && (cnt < CNT_MAX || !m0_req)) m1_gnt = 1'b1;
        else if (m0_req)                          m0_gnt = 1'b1;
      end
      default: begin
        // tie in IDLE goes to the port that was not served last
        if (m0_req && m1_req) begin
          m0_gnt = last;
          m1_gnt = !last;
        end else begin
          m0_gnt = m0_req;
          m1_gnt = m1_req;
        end
      end
    endcase
    if (m0_gnt) begin
      state_nxt = OWN0;
      last_nxt  = 1'b0;
      if (state == OWN0) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      else               cnt_nxt = CNT_ONE;
    end else if (m1_gnt) begin
      state_nxt = OWN1;
      last_nxt  = 1'b1;
      if (state == OWN1) cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_ONE;
      else               cnt_nxt = CNT_ONE;
    end
  end

  always_ff @(posedge clk or negedge a_reset_n) begin
    if (!a_reset_n) begin
      ram_we      <= 1'b0;
      ram_address <= '0;
      ram_wdata   <= '0;
      tag1        <= '0;
      tag2        <= '0;
    end else begin
      ram_we <= 1'b0;
      if (m0_gnt) begin
        ram_address <= m0_addr;
        ram_we      <= m0_we;
        ram_wdata   <= m0_wdata;
      end else if (m1_gnt) begin
        ram_address <= m1_addr;
        ram_we      <= m1_we;
        ram_wdata   <= m1_wdata;
      end
      tag1 <= {(m0_gnt && !m0_we) || (m1_gnt && !m1_we), m1_gnt};
      tag2 <= tag1;
    end
  end

  assign m0_rvalid = tag2[1] && !tag2[0];
  assign m1_rvalid = tag2[1] &&  tag2[0];
  assign m0_rdata  = ram_rdata;
  assign m1_rdata  = ram_rdata;

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios with literal expectations plus random
// traffic, all checked every cycle against a transaction-level model with a RAM image.
module tb_ram_arbiter;
  localparam int AW = 31;
  localparam int DW = 32;
  localparam int MB = 4;

  logic          clk = 1'b0;
  logic          a_reset_n = 1'b0;
  logic          m0_req = 0, m1_req = 0, m0_we = 0, m1_we = 0;
  logic [AW-1:0] m0_addr = '0, m1_addr = '0;
  logic [DW-1:0] m0_wdata = '0, m1_wdata = '0;
  logic          m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, ram_we;
  logic [DW-1:0] m0_rdata, m1_rdata, ram_wdata, ram_rdata;
  logic [AW-1:0] ram_address;

  ram_arbiter #(.RAM_WIDTH(AW), .DATA_WIDTH(DW), .MAX_BURST(MB)) dut (
    .clk(clk), .a_reset_n(a_reset_n),
    .m0_req(m0_req), .m1_req(m1_req), .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr), .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_gnt(m0_gnt), .m1_gnt(m1_gnt), .m0_rvalid(m0_rvalid), .m1_rvalid(m1_rvalid),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .ram_address(ram_address), .ram_we(ram_we), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous RAM: write at edge, read data one cycle after address.
  logic [DW-1:0] ram_mem   [256];
  logic [DW-1:0] model_mem [256];
  initial begin
    for (int i = 0; i < 256; i++) begin
      ram_mem[i]   = 32'hC0DE0000 + i;
      model_mem[i] = 32'hC0DE0000 + i;
    end
    ram_mem[16]   = 32'hDEADBEEF;
    model_mem[16] = 32'hDEADBEEF;
  end
  always @(posedge clk) begin
    if (ram_we) ram_mem[ram_address[7:0]] <= ram_wdata;
    ram_rdata <= ram_mem[ram_address[7:0]];
  end

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Transaction-level model: who owns the RAM, how long the run is, and what reads return.
  typedef struct {int due; int port; logic [DW-1:0] data;} ret_t;
  ret_t          rq[$];
  ret_t          r;
  int            owner = -1, streak = 0, lastp = 1, win;
  bit            own_req, oth_req, exp_rv0, exp_rv1;
  bit            pend_v = 0;
  logic [7:0]    pend_a;
  logic [DW-1:0] pend_d, exp_rd;
  logic          exp_we = 0;
  logic [AW-1:0] exp_addr = '0, w_addr;
  logic [DW-1:0] exp_wdata = '0, w_data;
  logic          w_we;

  always @(negedge clk) begin
    cyc++;
    if (!a_reset_n) begin
      chk("rst_ram_we", ram_we, 0);
      chk("rst_rvalid0", m0_rvalid, 0);
      chk("rst_rvalid1", m1_rvalid, 0);
      rq.delete();
      owner = -1; streak = 0; lastp = 1; pend_v = 0;
      exp_we = 0; exp_addr = '0; exp_wdata = '0;
    end else begin
      if (pend_v) model_mem[pend_a] = pend_d;
      pend_v = 0;
      chk("ram_we", ram_we, exp_we);
      chk("ram_address", ram_address, exp_addr);
      chk("ram_wdata", ram_wdata, exp_wdata);
      exp_rv0 = 0; exp_rv1 = 0; exp_rd = '0;
      if (rq.size() > 0 && rq[0].due == cyc) begin
        r = rq.pop_front();
        if (r.port == 0) exp_rv0 = 1; else exp_rv1 = 1;
        exp_rd = r.data;
      end
      chk("m0_rvalid", m0_rvalid, exp_rv0);
      chk("m1_rvalid", m1_rvalid, exp_rv1);
      if (exp_rv0) chk("m0_rdata", m0_rdata, exp_rd);
      if (exp_rv1) chk("m1_rdata", m1_rdata, exp_rd);

      win = -1;
      if (owner >= 0) begin
        own_req = (owner == 1) ? m1_req : m0_req;
        oth_req = (owner == 1) ? m0_req : m1_req;
        if (own_req && (streak < MB || !oth_req)) win = owner;
        else if (oth_req) win = 1 - owner;
      end else if (m0_req && m1_req) win = 1 - lastp;
      else if (m0_req) win = 0;
      else if (m1_req) win = 1;
      chk("m0_gnt", m0_gnt, win == 0);
      chk("m1_gnt", m1_gnt, win == 1);

      if (win < 0) begin
        owner = -1; streak = 0; exp_we = 0;
      end else begin
        streak = (win == owner) ? ((streak < MB) ? streak + 1 : MB) : 1;
        owner = win; lastp = win;
        w_addr = (win == 1) ? m1_addr : m0_addr;
        w_we   = (win == 1) ? m1_we : m0_we;
        w_data = (win == 1) ? m1_wdata : m0_wdata;
        exp_addr = w_addr; exp_we = w_we; exp_wdata = w_data;
        if (w_we) begin
          pend_v = 1; pend_a = w_addr[7:0]; pend_d = w_data;
        end else begin
          r.due = cyc + 2; r.port = win; r.data = model_mem[w_addr[7:0]];
          rq.push_back(r);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    m0_req = 0; m1_req = 0; a_reset_n = 0;
    step(); step();
    a_reset_n = 1;
  endtask

  task automatic set0(input logic q, input logic w, input int a, input logic [DW-1:0] d);
    m0_req = q; m0_we = w; m0_addr = AW'(a); m0_wdata = d;
  endtask

  task automatic set1(input logic q, input logic w, input int a, input logic [DW-1:0] d);
    m1_req = q; m1_we = w; m1_addr = AW'(a); m1_wdata = d;
  endtask

  int seq_a[10] = '{0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
  int seq_b[4]  = '{1, 1, 1, 0};
  logic g0, g1;

  initial begin
    // reset values
    step(); step();
    @(negedge clk);
    chk("reset_ram_address", ram_address, 0);
    chk("reset_ram_wdata", ram_wdata, 0);
    step();
    a_reset_n = 1;

    // single read of 0x10
    set0(1, 0, 'h10, 0);
    @(negedge clk); chk("rd_gnt", m0_gnt, 1);
    step(); m0_req = 0;
    @(negedge clk); chk("rd_addr", ram_address, 'h10); chk("rd_we", ram_we, 0);
    step();
    @(negedge clk); chk("rd_rvalid", m0_rvalid, 1); chk("rd_rdata", m0_rdata, 32'hDEADBEEF);
    chk("rd_m1_rvalid", m1_rvalid, 0);
    step();

    // continuous dual request from reset
    do_reset();
    set0(1, 0, 1, 0); set1(1, 0, 2, 0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("burst_onehot", m0_gnt + m1_gnt, 1);
      chk("burst_seq", m1_gnt ? 1 : 0, seq_a[i]);
      step();
    end
    m0_req = 0; m1_req = 0;

    // read-after-write across ports
    set1(1, 1, 'h20, 32'h12345678);
    @(negedge clk); chk("raw_wgnt", m1_gnt, 1);
    step(); m1_req = 0; set0(1, 0, 'h20, 0);
    @(negedge clk); chk("raw_rgnt", m0_gnt, 1);
    step(); m0_req = 0;
    @(negedge clk);
    step();
    @(negedge clk); chk("raw_rvalid", m0_rvalid, 1); chk("raw_rdata", m0_rdata, 32'h12345678);
    step();

    // owner drops request, other port takes over without a gap
    do_reset();
    set0(1, 0, 4, 0); set1(1, 0, 6, 0);
    @(negedge clk); chk("drop_g1", m0_gnt, 1);
    step();
    @(negedge clk); chk("drop_g2", m0_gnt, 1);
    step(); m0_req = 0;
    @(negedge clk); chk("drop_handover", m1_gnt, 1);
    step(); m0_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk); chk("drop_restart", m1_gnt ? 1 : 0, seq_b[i]);
      step();
    end
    m0_req = 0; m1_req = 0;
    step();

    // idle after a write holds address/data, drops we, returns to IDLE
    set0(1, 1, 'h3C, 32'hA5A5A5A5);
    @(negedge clk); chk("idle_wgnt", m0_gnt, 1);
    step(); m0_req = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      @(negedge clk);
      chk("idle_we", ram_we, 0);
      chk("idle_addr", ram_address, 'h3C);
      chk("idle_wdata", ram_wdata, 32'hA5A5A5A5);
    end
    step();
    set0(1, 0, 7, 0); set1(1, 0, 8, 0);
    @(negedge clk); chk("idle_tie", m1_gnt, 1);
    step(); m0_req = 0; m1_req = 0;
    step();

    // reset in the middle of traffic
    do_reset();
    set0(1, 0, 0, 0);
    step(); m0_addr = AW'(1);
    step(); m0_req = 0; set1(1, 1, 'h30, 32'hCAFEF00D);
    @(negedge clk); chk("mid_wgnt", m1_gnt, 1);
    step(); m1_req = 0; a_reset_n = 0;
    @(negedge clk); chk("mid_we_async", ram_we, 0); chk("mid_rvalid_drop", m0_rvalid, 0);
    step(); step();
    a_reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); chk("mid_no_rvalid", m0_rvalid, 0);
      step();
    end
    set0(1, 0, 2, 0); set1(1, 0, 5, 0);
    @(negedge clk); chk("mid_tie", m0_gnt, 1);
    step(); m0_addr = AW'(3);
    @(negedge clk);
    step(); m0_req = 0; m1_req = 0;
    step(); step(); step();

    // random traffic against the model
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk); g0 = m0_gnt; g1 = m1_gnt;
      step();
      if (!m0_req || g0)
        set0($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
      if (!m1_req || g1)
        set1($urandom_range(0, 9) < 7, $urandom_range(0, 2) == 0, $urandom_range(0, 15), $urandom);
    end
    m0_req = 0; m1_req = 0;
    step(); step(); step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish (got running, expected finished)");
    $fatal(1);
  end
endmodule
